iomem_table_loader: RTL and testbench
=====================================

Name: iomem_table_loader

Overview:
- Parametrised iomem slave that programs the TCAM key/mask tables and the action table from the PicoRV32 iomem bus.
- Firmware stages wide key and action values one 32-bit word at a time, then commits them to a selected entry with single-cycle write strobes.
- Adds hardware bulk-clear of every entry, busy/error status, readback of staged words, and a completion interrupt pulse.
- Sits beside the SoC core and decodes one iomem address window.

Parameters:
- KEY_W, 128, TCAM key/mask width in bits (any value ≥1).
- ENTRIES, 16, table depth.
- IDX_W, $clog2(ENTRIES), entry index width.
- ACTION_W, 64, action word width (any value ≥1).
- BASE_HI, 8'h04, value of iomem_addr[31:24] that selects this block.
- KW, (KEY_W+31)/32, number of key staging words (derived).
- AW, (ACTION_W+31)/32, number of action staging words (derived).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- tcam_wr_addr  out  IDX_W  TCAM entry index
- tcam_wr_is_mask  out  1  1 = mask plane, 0 = key plane
- tcam_wr_data  out  KEY_W  TCAM write data
- tcam_wr_en  out  1  TCAM write strobe, one cycle per write
- action_wr_en  out  1  action write strobe
- action_wr_addr  out  IDX_W  action entry index
- action_wr_data  out  ACTION_W  action write data
- action_wr_default  out  1  default-action write strobe
- action_default_data  out  ACTION_W  held copy of the last committed default action
- irq_done  out  1  one-cycle pulse when a commit or clear sequence finishes

Behaviour:
- Reset, asynchronous on resetn low: every output is 0. Staging registers, the index register, the error bit and the FSM return to zero/IDLE. Any sequence in flight is abandoned; no further strobes are issued.
- Decode: the block is selected when iomem_addr[31:24]==BASE_HI. Register offset is iomem_addr[11:0].
- Bus handshake:
  - When valid && selected && !ready, the block asserts ready for exactly one cycle.
  - Ready always deasserts the following cycle, so back-to-back accesses take 2 cycles each.
  - Write effects are applied at the same edge that raises ready.
  - Unselected addresses: the block never asserts ready.
  - Unmapped offsets inside the window: read returns 0, writes are ignored, ready is still given.
  - Byte strobes apply to every writable register.
- Register map:
  - 0x000 CTRL (write):
    - bit0 commit key; bit1 commit mask; bit2 commit action; bit3 commit default; bit4 clear-all.
    - A write with all of bits 0-4 clear has no effect.
  - 0x000 STATUS (read): bit0 busy; bit1 error (sticky); [31:16] ENTRIES.
  - 0x004 INDEX (R/W): the low IDX_W bits are stored. A write with value ≥ ENTRIES sets error and leaves INDEX unchanged.
  - 0x008 ERRCLR: a write of any value clears error.
  - 0x100+4k, k<KW: key staging word k (R/W). Bits above KEY_W in the top word read 0.
  - 0x200+4k, k<AW: action staging word k (R/W), same rule for bits above ACTION_W.
- FSM states: IDLE, KEY, MASK, ACT, CLR_A, CLR_B, DONE. busy=1 in every state except IDLE.
- Commit sequence, from IDLE on a CTRL write:
  - The FSM visits KEY, MASK and ACT in that order, skipping any whose bit is clear. Each visited state lasts 1 cycle.
  - KEY: tcam_wr_en=1, is_mask=0, data=key staging.
  - MASK: tcam_wr_en=1, is_mask=1, data=key staging, so firmware reloads the staging words with the mask between commits.
  - ACT: bit2 gives action_wr_en=1 with data=action staging; bit3 gives action_wr_default=1 and action_default_data is loaded from action staging. Bits 2 and 3 may both fire in the same ACT cycle.
  - Entry address for every strobe is INDEX latched at the CTRL write.
  - The first strobe occurs in the cycle after ready.
- Clear-all: bit4 overrides bits 0-3. For i = 0 to ENTRIES-1:
  - CLR_A: tcam key write of 0 and action write of 0 to entry i, in the same cycle.
  - CLR_B: tcam mask write of 0 to entry i.
  - Total 2*ENTRIES strobe cycles. The counter ends at ENTRIES-1 and does not wrap.
- DONE: 1 cycle with irq_done=1, then IDLE. All strobes are 0 outside their own states.
- Writes while busy:
  - A CTRL write sets error and is ignored.
  - INDEX and staging writes are accepted; the running sequence uses its latched index and live staging values.
  - Firmware polls busy before restaging.
- Data and address outputs hold their last value between strobes.

Test Plan:
- Reset: hold resetn=0 mid-clear → all outputs 0 immediately; after release STATUS reads 0x0010_0000 (ENTRIES=16).
- Stage key words = 0xDEADBEEF,0x01234567,0x89ABCDEF,0x0F0F0F0F, INDEX=5, CTRL=0x1 → one tcam_wr_en cycle with addr=5, is_mask=0, data=0x0F0F0F0F_89ABCDEF_01234567_DEADBEEF, then irq_done the next cycle.
- CTRL=0xF with INDEX=3 → KEY, MASK, ACT on consecutive cycles; in ACT, action_wr_en and action_wr_default are both 1; action_default_data equals action staging; busy reads 1 throughout.
- CTRL=0x10 → 32 strobe cycles covering entries 0..15 in order, all data 0, then exactly one irq_done pulse.
- INDEX=16 write → error=1 and INDEX unchanged; CTRL write during clear → error=1 and no extra strobes; ERRCLR → error=0.
- Read offset 0x300 → rdata=0 with ready; access with addr[31:24]=0x03 → ready stays 0.

Source files
------------

// File: rtl/iomem_table_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | iomem_table_loader: iomem slave that stages key/action words and commits   |
// | them to TCAM/action tables, with bulk clear, status and done interrupt.    |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module iomem_table_loader #(
    parameter int          KEY_W    = 128,
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = $clog2(ENTRIES),
    parameter int          ACTION_W = 64,
    parameter logic [7:0]  BASE_HI  = 8'h04,
    parameter int          KW       = (KEY_W + 31) / 32,
    parameter int          AW       = (ACTION_W + 31) / 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    output logic [IDX_W-1:0]    tcam_wr_addr,
    output logic                tcam_wr_is_mask,
    output logic [KEY_W-1:0]    tcam_wr_data,
    output logic                tcam_wr_en,
    output logic                action_wr_en,
    output logic [IDX_W-1:0]    action_wr_addr,
    output logic [ACTION_W-1:0] action_wr_data,
    output logic                action_wr_default,
    output logic [ACTION_W-1:0] action_default_data,
    output logic                irq_done
);

    localparam logic [9:0]          c_KEY_BASE = 10'h040;
    localparam logic [9:0]          c_ACT_BASE = 10'h080;
    localparam logic [9:0]          c_KW       = 10'(KW);
    localparam logic [9:0]          c_AW       = 10'(AW);
    localparam logic [KW*32-1:0]    c_KEY_MASK = {(KW*32){1'b1}} >> (KW*32 - KEY_W);
    localparam logic [AW*32-1:0]    c_ACT_MASK = {(AW*32){1'b1}} >> (AW*32 - ACTION_W);
    localparam logic [IDX_W-1:0]    c_LAST     = IDX_W'(ENTRIES - 1);
    localparam logic [31:0]         c_ENTRIES  = 32'(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_MASK  = 3'd2,
        S_ACT   = 3'd3,
        S_CLR_A = 3'd4,
        S_CLR_B = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           ops_q, ops_d;
    logic [IDX_W-1:0]     lidx_q, lidx_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 err_q, err_d;
    logic [KW*32-1:0]     key_q, key_d;
    logic [AW*32-1:0]     act_q, act_d;
    logic                 ready_q;
    logic [31:0]          rdata_q;

    logic                 tcam_en_q, tcam_mask_q, act_en_q, def_en_q, irq_q;
    logic [IDX_W-1:0]     tcam_addr_q, act_addr_q;
    logic [KEY_W-1:0]     tcam_data_q;
    logic [ACTION_W-1:0]  act_data_q, def_data_q;

    logic                 w_sel, w_acc, w_wr, w_rd, w_busy;
    logic [9:0]           w_word, w_key_k, w_act_k;
    logic                 w_key_hit, w_act_hit;
    logic [4:0]           w_ctrl_bits;
    logic                 w_start, w_ctrl_err;
    logic [31:0]          w_idx_new, w_rd_val;
    logic                 w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign w_unused    = ^{iomem_addr[23:12], iomem_addr[1:0]};
    assign w_sel       = (iomem_addr[31:24] == BASE_HI);
    assign w_acc       = iomem_valid && w_sel && !ready_q;
    assign w_wr        = w_acc && (iomem_wstrb != 4'd0);
    assign w_rd        = w_acc && (iomem_wstrb == 4'd0);
    assign w_busy      = (state_q != S_IDLE);
    assign w_word      = iomem_addr[11:2];
    assign w_key_k     = w_word - c_KEY_BASE;
    assign w_act_k     = w_word - c_ACT_BASE;
    assign w_key_hit   = (w_word >= c_KEY_BASE) && (w_key_k < c_KW);
    assign w_act_hit   = (w_word >= c_ACT_BASE) && (w_act_k < c_AW);
    assign w_ctrl_bits = iomem_wstrb[0] ? iomem_wdata[4:0] : 5'd0;
    assign w_start     = w_wr && (w_word == 10'd0) && !w_busy && (w_ctrl_bits != 5'd0);
    assign w_ctrl_err  = w_wr && (w_word == 10'd0) && w_busy;
    assign w_idx_new   = f_merge(32'(index_q), iomem_wdata, iomem_wstrb);

    always_comb begin
        w_rd_val = 32'd0;
        if (w_word == 10'd0) begin
            w_rd_val = {16'(ENTRIES), 14'd0, err_q, w_busy};
        end else if (w_word == 10'd1) begin
            w_rd_val = 32'(index_q);
        end else if (w_key_hit) begin
            for (int k = 0; k < KW; k++) begin
                if (w_key_k == 10'(k)) w_rd_val = key_q[k*32 +: 32];
            end
        end else if (w_act_hit) begin
            for (int k = 0; k < AW; k++) begin
                if (w_act_k == 10'(k)) w_rd_val = act_q[k*32 +: 32];
            end
        end
    end

    // Staging words are stored pre-masked so readback of unused top bits is 0.
    always_comb begin
        key_d = key_q;
        act_d = act_q;
        if (w_wr && w_key_hit) begin
            for (int k = 0; k < KW; k++) begin
                if (w_key_k == 10'(k)) key_d[k*32 +: 32] = f_merge(key_q[k*32 +: 32], iomem_wdata, iomem_wstrb);
            end
        end
        if (w_wr && w_act_hit) begin
            for (int k = 0; k < AW; k++) begin
                if (w_act_k == 10'(k)) act_d[k*32 +: 32] = f_merge(act_q[k*32 +: 32], iomem_wdata, iomem_wstrb);
            end
        end
        key_d = key_d & c_KEY_MASK;
        act_d = act_d & c_ACT_MASK;
    end

    always_comb begin
        index_d = index_q;
        err_d   = err_q;
        if (w_wr && (w_word == 10'd2)) err_d = 1'b0;
        if (w_wr && (w_word == 10'd1)) begin
            if (w_idx_new < c_ENTRIES) index_d = w_idx_new[IDX_W-1:0];
            else                       err_d   = 1'b1;
        end
        if (w_ctrl_err) err_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        lidx_d  = lidx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    ops_d  = w_ctrl_bits[3:0];
                    lidx_d = index_q;
                    cnt_d  = '0;
                    if (w_ctrl_bits[4])      state_d = S_CLR_A;
                    else if (w_ctrl_bits[0]) state_d = S_KEY;
                    else if (w_ctrl_bits[1]) state_d = S_MASK;
                    else                     state_d = S_ACT;
                end
            end
            S_KEY: begin
                if (ops_q[1])             state_d = S_MASK;
                else if (|ops_q[3:2])     state_d = S_ACT;
                else                      state_d = S_DONE;
            end
            S_MASK:  state_d = (|ops_q[3:2]) ? S_ACT : S_DONE;
            S_ACT:   state_d = S_DONE;
            S_CLR_A: state_d = S_CLR_B;
            S_CLR_B: begin
                if (cnt_q == c_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_CLR_A;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ops_q   <= '0;
            lidx_q  <= '0;
            cnt_q   <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
            key_q   <= '0;
            act_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            lidx_q  <= lidx_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            err_q   <= err_d;
            key_q   <= key_d;
            act_q   <= act_d;
            ready_q <= w_acc;
            rdata_q <= w_rd ? w_rd_val : 32'd0;
        end
    end

    // Strobes are registered from the current state, so each lands one cycle after its state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcam_en_q   <= 1'b0;
            tcam_mask_q <= 1'b0;
            tcam_addr_q <= '0;
            tcam_data_q <= '0;
            act_en_q    <= 1'b0;
            act_addr_q  <= '0;
            act_data_q  <= '0;
            def_en_q    <= 1'b0;
            def_data_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            tcam_en_q <= 1'b0;
            act_en_q  <= 1'b0;
            def_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            case (state_q)
                S_KEY, S_MASK: begin
                    tcam_en_q   <= 1'b1;
                    tcam_mask_q <= (state_q == S_MASK);
                    tcam_addr_q <= lidx_q;
                    tcam_data_q <= key_q[KEY_W-1:0];
                end
                S_ACT: begin
                    if (ops_q[2]) begin
                        act_en_q   <= 1'b1;
                        act_addr_q <= lidx_q;
                        act_data_q <= act_q[ACTION_W-1:0];
                    end
                    if (ops_q[3]) begin
                        def_en_q   <= 1'b1;
                        def_data_q <= act_q[ACTION_W-1:0];
                    end
                end
                S_CLR_A: begin
                    tcam_en_q   <= 1'b1;
                    tcam_mask_q <= 1'b0;
                    tcam_addr_q <= cnt_q;
                    tcam_data_q <= '0;
                    act_en_q    <= 1'b1;
                    act_addr_q  <= cnt_q;
                    act_data_q  <= '0;
                end
                S_CLR_B: begin
                    tcam_en_q   <= 1'b1;
                    tcam_mask_q <= 1'b1;
                    tcam_addr_q <= cnt_q;
                    tcam_data_q <= '0;
                end
                S_DONE:  irq_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign iomem_ready         = ready_q;
    assign iomem_rdata         = rdata_q;
    assign tcam_wr_en          = tcam_en_q;
    assign tcam_wr_is_mask     = tcam_mask_q;
    assign tcam_wr_addr        = tcam_addr_q;
    assign tcam_wr_data        = tcam_data_q;
    assign action_wr_en        = act_en_q;
    assign action_wr_addr      = act_addr_q;
    assign action_wr_data      = act_data_q;
    assign action_wr_default   = def_en_q;
    assign action_default_data = def_data_q;
    assign irq_done            = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_table_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_iomem_table_loader: randomized bus stimulus with a queue scoreboard     |
// | against a register/strobe-level reference model.                           |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module tb_iomem_table_loader;

    localparam int KEY_W = 128, ENTRIES = 16, IDX_W = 4, ACTION_W = 64;

    logic                clk = 1'b0, resetn = 1'b0;
    logic                iomem_valid = 1'b0, iomem_ready;
    logic [3:0]          iomem_wstrb = 4'd0;
    logic [31:0]         iomem_addr = 32'd0, iomem_wdata = 32'd0, iomem_rdata;
    logic [IDX_W-1:0]    tcam_wr_addr, action_wr_addr;
    logic                tcam_wr_is_mask, tcam_wr_en, action_wr_en, action_wr_default, irq_done;
    logic [KEY_W-1:0]    tcam_wr_data;
    logic [ACTION_W-1:0] action_wr_data, action_default_data;

    iomem_table_loader #(.KEY_W(KEY_W), .ENTRIES(ENTRIES), .ACTION_W(ACTION_W), .BASE_HI(8'h04)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .tcam_wr_addr(tcam_wr_addr), .tcam_wr_is_mask(tcam_wr_is_mask),
        .tcam_wr_data(tcam_wr_data), .tcam_wr_en(tcam_wr_en), .action_wr_en(action_wr_en),
        .action_wr_addr(action_wr_addr), .action_wr_data(action_wr_data),
        .action_wr_default(action_wr_default), .action_default_data(action_default_data),
        .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ten; bit tmask; logic [3:0] taddr; logic [127:0] tdata;
        bit aen; logic [3:0] aaddr; logic [63:0] adata;
        bit def; logic [63:0] defdata; bit irq;
    } ev_t;
    typedef struct { bit is_read; logic [31:0] exp; string name; } rd_t;

    ev_t evq[$];
    rd_t rdq[$];
    int  errors = 0, checks = 0;

    // Reference model: architectural registers and the busy window of the running sequence.
    logic [31:0] m_key[4];
    logic [31:0] m_act[2];
    int          m_idx;
    bit          m_err;
    logic [63:0] m_def;
    time         busy_from, busy_to;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_key[i] = 32'd0;
        for (int i = 0; i < 2; i++) m_act[i] = 32'd0;
        m_idx = 0; m_err = 0; m_def = 64'd0; busy_from = 0; busy_to = 0;
    endfunction

    function automatic bit m_busy(time e);
        return (e > busy_from) && (e <= busy_to);
    endfunction

    function automatic logic [31:0] merge32(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic ev_t ev_zero();
        ev_t x;
        x.ten = 0; x.tmask = 0; x.taddr = 0; x.tdata = 0; x.aen = 0; x.aaddr = 0;
        x.adata = 0; x.def = 0; x.defdata = m_def; x.irq = 0;
        return x;
    endfunction

    function automatic void plan(logic [4:0] b, time e);
        ev_t x;
        int  n = 0;
        if (b[4]) begin
            for (int i = 0; i < ENTRIES; i++) begin
                x = ev_zero(); x.ten = 1; x.taddr = 4'(i); x.aen = 1; x.aaddr = 4'(i);
                evq.push_back(x);
                x = ev_zero(); x.ten = 1; x.tmask = 1; x.taddr = 4'(i);
                evq.push_back(x);
                n += 2;
            end
        end else begin
            if (b[0]) begin
                x = ev_zero(); x.ten = 1; x.taddr = 4'(m_idx);
                x.tdata = {m_key[3], m_key[2], m_key[1], m_key[0]};
                evq.push_back(x); n++;
            end
            if (b[1]) begin
                x = ev_zero(); x.ten = 1; x.tmask = 1; x.taddr = 4'(m_idx);
                x.tdata = {m_key[3], m_key[2], m_key[1], m_key[0]};
                evq.push_back(x); n++;
            end
            if (b[2] || b[3]) begin
                if (b[3]) m_def = {m_act[1], m_act[0]};
                x = ev_zero(); x.aen = b[2]; x.aaddr = 4'(m_idx); x.adata = {m_act[1], m_act[0]};
                x.def = b[3];
                evq.push_back(x); n++;
            end
        end
        x = ev_zero(); x.irq = 1;
        evq.push_back(x);
        busy_from = e;
        busy_to   = e + time'((n + 1) * 10);
    endfunction

    function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s, time e);
        int w;
        logic [31:0] nv;
        if (a[31:24] != 8'h04) return;
        w = int'(a[11:2]);
        if (w == 0) begin
            if (m_busy(e)) m_err = 1;
            else if ((s[0] ? d[4:0] : 5'd0) != 5'd0) plan(d[4:0], e);
        end else if (w == 1) begin
            nv = merge32(32'(m_idx), d, s);
            if (nv >= ENTRIES) m_err = 1; else m_idx = int'(nv);
        end else if (w == 2) begin
            m_err = 0;
        end else if (w >= 'h40 && w < 'h44) begin
            m_key[w-'h40] = merge32(m_key[w-'h40], d, s);
        end else if (w >= 'h80 && w < 'h82) begin
            m_act[w-'h80] = merge32(m_act[w-'h80], d, s);
        end
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, time e);
        int w = int'(a[11:2]);
        if (w == 0) return {16'(ENTRIES), 14'd0, m_err, m_busy(e)};
        if (w == 1) return 32'(m_idx);
        if (w >= 'h40 && w < 'h44) return m_key[w-'h40];
        if (w >= 'h80 && w < 'h82) return m_act[w-'h80];
        return 32'd0;
    endfunction

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output bit ok, output time e);
        @(negedge clk);
        iomem_valid = 1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) ok = 1;
        end
        e = $time - 1;
        iomem_valid = 0; iomem_wstrb = 4'd0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL bus_timeout addr=%h: no ready within 20 cycles", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok; time e;
        bus(a, d, s, ok, e);
        if (ok) begin
            rdq.push_back('{is_read: 1'b0, exp: 32'd0, name: "wr"});
            model_write(a, d, s, e);
        end
    endtask

    task automatic rd(input logic [31:0] a, input string n);
        bit ok; time e;
        bus(a, 32'd0, 4'd0, ok, e);
        if (ok) rdq.push_back('{is_read: 1'b1, exp: model_read(a, e), name: n});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && evq.size() != 0; i++) @(negedge clk);
        if (evq.size() != 0) begin
            checks++; errors++;
            $display("FAIL seq_timeout: %0d strobe events still pending, want 0", evq.size());
            evq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a strobe or a bus acknowledge.
    always @(negedge clk) begin
        if (resetn) begin
            if (tcam_wr_en || action_wr_en || action_wr_default || irq_done) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got ten=%0b aen=%0b def=%0b irq=%0b, want none",
                             tcam_wr_en, action_wr_en, action_wr_default, irq_done);
                end else begin
                    ev_t x;
                    bit  ok;
                    x  = evq.pop_front();
                    ok = (tcam_wr_en == x.ten) && (action_wr_en == x.aen) && (action_wr_default == x.def)
                         && (irq_done == x.irq) && (action_default_data == x.defdata);
                    if (x.ten) ok = ok && (tcam_wr_is_mask == x.tmask) && (tcam_wr_addr == x.taddr)
                                       && (tcam_wr_data == x.tdata);
                    if (x.aen) ok = ok && (action_wr_addr == x.aaddr) && (action_wr_data == x.adata);
                    if (!ok) begin
                        errors++;
                        $display("FAIL strobe: got ten=%0b m=%0b ta=%0d td=%h aen=%0b aa=%0d ad=%h def=%0b dd=%h irq=%0b; want ten=%0b m=%0b ta=%0d td=%h aen=%0b aa=%0d ad=%h def=%0b dd=%h irq=%0b",
                                 tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data, action_wr_en,
                                 action_wr_addr, action_wr_data, action_wr_default, action_default_data, irq_done,
                                 x.ten, x.tmask, x.taddr, x.tdata, x.aen, x.aaddr, x.adata, x.def, x.defdata, x.irq);
                    end
                end
            end
            if (iomem_ready) begin
                if (rdq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ready_unexpected: got ready=1 addr=%h, want 0", iomem_addr);
                end else begin
                    rd_t r;
                    r = rdq.pop_front();
                    if (r.is_read) begin
                        checks++;
                        if (iomem_rdata !== r.exp) begin
                            errors++;
                            $display("FAIL read_%s: got %h, want %h", r.name, iomem_rdata, r.exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] kw[4];
        bit          seen;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1;

        rd(32'h0400_0000, "status_reset");
        rd(32'h0400_0004, "index_reset");

        // Directed key commit.
        kw[0] = 32'hDEADBEEF; kw[1] = 32'h01234567; kw[2] = 32'h89ABCDEF; kw[3] = 32'h0F0F0F0F;
        for (int k = 0; k < 4; k++) wr(32'h0400_0100 + 32'(4*k), kw[k], 4'hF);
        wr(32'h0400_0004, 32'd5, 4'hF);
        wr(32'h0400_0000, 32'h1, 4'hF);
        wait_done();
        rd(32'h0400_0108, "key2_readback");

        // Full commit: key, mask, action and default in consecutive cycles.
        wr(32'h0400_0200, $urandom, 4'hF);
        wr(32'h0400_0204, $urandom, 4'hF);
        wr(32'h0400_0004, 32'd3, 4'hF);
        wr(32'h0400_0000, 32'hF, 4'hF);
        rd(32'h0400_0000, "status_busy_f");
        rd(32'h0400_0000, "status_busy_f2");
        wait_done();

        // Randomized staging (with partial byte strobes) and commit combinations.
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 4; k++) wr(32'h0400_0100 + 32'(4*k), $urandom, 4'($urandom_range(1, 15)));
            for (int k = 0; k < 2; k++) wr(32'h0400_0200 + 32'(4*k), $urandom, 4'($urandom_range(1, 15)));
            wr(32'h0400_0004, 32'($urandom_range(0, 15)), 4'hF);
            rd(32'h0400_0100 + 32'(4*$urandom_range(0, 3)), "key_rand");
            rd(32'h0400_0200 + 32'(4*$urandom_range(0, 1)), "act_rand");
            wr(32'h0400_0000, 32'($urandom_range(1, 15)), 4'hF);
            rd(32'h0400_0000, "status_rand");
            wait_done();
            rd(32'h0400_0000, "status_idle");
        end

        // Index range error, sticky error, and clear.
        wr(32'h0400_0004, 32'd9, 4'hF);
        wr(32'h0400_0004, 32'd16, 4'hF);
        rd(32'h0400_0004, "index_kept");
        rd(32'h0400_0000, "status_err");
        wr(32'h0400_0008, 32'd0, 4'hF);
        rd(32'h0400_0000, "status_errclr");

        // Clear-all with a rejected CTRL write and an accepted INDEX write while busy.
        wr(32'h0400_0000, 32'h10, 4'hF);
        wr(32'h0400_0000, 32'h1, 4'hF);
        wr(32'h0400_0004, 32'd7, 4'hF);
        rd(32'h0400_0000, "status_clr_busy");
        wait_done();
        rd(32'h0400_0004, "index_during_busy");
        rd(32'h0400_0000, "status_after_clr");
        wr(32'h0400_0008, 32'hFFFF_FFFF, 4'hF);

        // Unmapped offsets and unselected window.
        wr(32'h0400_0300, 32'h1234_5678, 4'hF);
        rd(32'h0400_0300, "unmapped");
        @(negedge clk);
        iomem_valid = 1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'd0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) seen = 1;
        end
        iomem_valid = 0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL unselected_ready: got ready=1, want 0");
        end

        // Asynchronous reset in the middle of a clear.
        wr(32'h0400_0000, 32'h10, 4'hF);
        repeat (9) @(negedge clk);
        #2 resetn = 0;
        #1;
        checks++;
        if ({iomem_ready, iomem_rdata, tcam_wr_addr, tcam_wr_is_mask, tcam_wr_data, tcam_wr_en,
             action_wr_en, action_wr_addr, action_wr_data, action_wr_default, action_default_data,
             irq_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tcam_en=%0b aen=%0b ta=%0d dd=%h ready=%0b, want all 0",
                     tcam_wr_en, action_wr_en, tcam_wr_addr, action_default_data, iomem_ready);
        end
        evq.delete();
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1;
        repeat (4) @(negedge clk);
        rd(32'h0400_0000, "status_post_reset");
        rd(32'h0400_0100, "key0_post_reset");
        repeat (3) @(negedge clk);

        checks++;
        if (evq.size() != 0 || rdq.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got ev=%0d rd=%0d, want 0 0", evq.size(), rdq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
